// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: 5-stage stall/flush network with a mul/div scoreboard, a fence-drain FSM and a data-bus timeout.
module hazard_scoreboard_unit #(
  parameter int REG_BITS       = 5,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_BITS       = 9,
  localparam int NUM_REGS      = 2**REG_BITS
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [REG_BITS-1:0] decode_rs1_unreg_in,
  input  logic                decode_rs1_read_unreg_in,
  input  logic [REG_BITS-1:0] decode_rs2_unreg_in,
  input  logic                decode_rs2_read_unreg_in,
  input  logic [REG_BITS-1:0] decode_rd_unreg_in,
  input  logic                decode_rd_write_unreg_in,
  input  logic                decode_mem_fence_unreg_in,
  input  logic                decode_mem_read_in,
  input  logic                decode_mem_fence_in,
  input  logic [REG_BITS-1:0] decode_rd_in,
  input  logic                decode_rd_write_in,
  input  logic                execute_mem_fence_in,
  input  logic                execute_issue_valid_in,
  input  logic [REG_BITS-1:0] execute_issue_rd_in,
  input  logic                wb_complete_valid_in,
  input  logic [REG_BITS-1:0] wb_complete_rd_in,
  input  logic                mem_rd_write_in,
  input  logic                mem_branch_mispredicted_in,
  input  logic                instr_read_in,
  input  logic                instr_ready_in,
  input  logic                data_read_in,
  input  logic                data_write_in,
  input  logic                data_ready_in,
  output logic                fetch_stall_out,
  output logic                fetch_flush_out,
  output logic                decode_stall_out,
  output logic                decode_flush_out,
  output logic                execute_stall_out,
  output logic                execute_flush_out,
  output logic                mem_stall_out,
  output logic                mem_flush_out,
  output logic [NUM_REGS-1:0] scoreboard_busy_out,
  output logic [REG_BITS:0]   scoreboard_count_out,
  output logic                fence_draining_out,
  output logic                data_timeout_out
);
  typedef enum logic {IDLE, DRAIN} state_e;
  state_e              state_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_BITS:0]   count_q, count_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic                timeout_q;
  logic                sb_wait, load_use, fence_seen, fetch_bus_wait, mem_bus_wait, wb_conflict, set_en;
  assign sb_wait = (decode_rs1_read_unreg_in && busy_q[decode_rs1_unreg_in]) ||
                   (decode_rs2_read_unreg_in && busy_q[decode_rs2_unreg_in]) ||
                   (decode_rd_write_unreg_in && busy_q[decode_rd_unreg_in]);
  assign load_use = decode_rd_in != '0 && decode_mem_read_in && decode_rd_write_in &&
                    ((decode_rs1_read_unreg_in && decode_rs1_unreg_in == decode_rd_in) ||
                     (decode_rs2_read_unreg_in && decode_rs2_unreg_in == decode_rd_in));
  assign fence_seen     = decode_mem_fence_unreg_in || decode_mem_fence_in || execute_mem_fence_in || state_q == DRAIN;
  assign fetch_bus_wait = instr_read_in && !instr_ready_in;
  assign mem_bus_wait   = (data_read_in || data_write_in) && !data_ready_in;
  assign wb_conflict    = wb_complete_valid_in && mem_rd_write_in;
  assign mem_stall_out     = mem_bus_wait || wb_conflict;
  assign mem_flush_out     = execute_stall_out;
  assign execute_stall_out = mem_stall_out;
  assign execute_flush_out = decode_stall_out || mem_branch_mispredicted_in;
  assign decode_stall_out  = execute_stall_out;
  assign decode_flush_out  = fetch_stall_out || mem_branch_mispredicted_in;
  assign fetch_stall_out   = decode_stall_out || load_use || sb_wait || fence_seen || fetch_bus_wait;
  assign fetch_flush_out   = 1'b0;
  // An issue alongside a mispredict is a squashed younger op; set is applied after clear so it wins.
  assign set_en = execute_issue_valid_in && !execute_stall_out && !mem_branch_mispredicted_in &&
                  execute_issue_rd_in != '0;
  always_comb begin
    busy_d = busy_q;
    if (wb_complete_valid_in) busy_d[wb_complete_rd_in] = 1'b0;
    if (set_en) busy_d[execute_issue_rd_in] = 1'b1;
    busy_d[0] = 1'b0;
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) count_d = count_d + (REG_BITS+1)'(busy_d[i]);
  end
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      busy_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      if (state_q == IDLE && execute_mem_fence_in && !execute_stall_out) state_q <= DRAIN;
      else if (state_q == DRAIN && busy_q == '0 && !mem_bus_wait) state_q <= IDLE;
      if (!mem_bus_wait) begin
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else if (cnt_q == CNT_BITS'(TIMEOUT_CYCLES-1)) begin
        cnt_q     <= '0;
        timeout_q <= 1'b1;
      end else begin
        cnt_q     <= cnt_q + 1'b1;
        timeout_q <= 1'b0;
      end
    end
  end
  assign scoreboard_busy_out  = busy_q;
  assign scoreboard_count_out = count_q;
  assign fence_draining_out   = state_q == DRAIN;
  assign data_timeout_out     = timeout_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed plan steps plus random traffic checked against a behavioural model.
module tb_hazard_scoreboard_unit;
  localparam int RB = 5, NR = 32, TO = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [RB-1:0] rs1, rs2, rdu, d_rd, iss_rd, wb_rd;
  logic rs1_rd, rs2_rd, rdu_wr, fence_u, d_load, d_fence, d_rd_wr, e_fence, iss_v, wb_v, m_rd_wr, mispred;
  logic i_read, i_ready, d_read, d_write, d_ready;
  logic fs, ff, ds, df, es, ef, ms, mf, drain, tout;
  logic [NR-1:0] busy;
  logic [RB:0] count;
  int checks = 0, errors = 0;
  bit m_busy[NR];
  bit m_drain, m_to;
  int m_cnt;

  hazard_scoreboard_unit #(.REG_BITS(RB), .TIMEOUT_CYCLES(TO), .CNT_BITS(3)) dut (
    .clk_in(clk), .reset_n_in(rst_n),
    .decode_rs1_unreg_in(rs1), .decode_rs1_read_unreg_in(rs1_rd),
    .decode_rs2_unreg_in(rs2), .decode_rs2_read_unreg_in(rs2_rd),
    .decode_rd_unreg_in(rdu), .decode_rd_write_unreg_in(rdu_wr),
    .decode_mem_fence_unreg_in(fence_u), .decode_mem_read_in(d_load),
    .decode_mem_fence_in(d_fence), .decode_rd_in(d_rd), .decode_rd_write_in(d_rd_wr),
    .execute_mem_fence_in(e_fence), .execute_issue_valid_in(iss_v), .execute_issue_rd_in(iss_rd),
    .wb_complete_valid_in(wb_v), .wb_complete_rd_in(wb_rd), .mem_rd_write_in(m_rd_wr),
    .mem_branch_mispredicted_in(mispred), .instr_read_in(i_read), .instr_ready_in(i_ready),
    .data_read_in(d_read), .data_write_in(d_write), .data_ready_in(d_ready),
    .fetch_stall_out(fs), .fetch_flush_out(ff), .decode_stall_out(ds), .decode_flush_out(df),
    .execute_stall_out(es), .execute_flush_out(ef), .mem_stall_out(ms), .mem_flush_out(mf),
    .scoreboard_busy_out(busy), .scoreboard_count_out(count),
    .fence_draining_out(drain), .data_timeout_out(tout));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic clear();
    {rs1, rs2, rdu, d_rd, iss_rd, wb_rd} = '0;
    {rs1_rd, rs2_rd, rdu_wr, fence_u, d_load, d_fence, d_rd_wr, e_fence, iss_v, wb_v, m_rd_wr, mispred} = '0;
    {i_read, d_read, d_write} = '0;
    i_ready = 1; d_ready = 1;
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_drain = 0; m_cnt = 0; m_to = 0;
  endtask

  // Check every output against the model at the negedge, then advance the model across the posedge.
  task automatic step(input string tag);
    bit bw, stall, lu, sb, fence, fstall;
    bit n_busy[NR];
    @(negedge clk);
    bw     = (d_read || d_write) && !d_ready;
    stall  = bw || (wb_v && m_rd_wr);
    lu     = d_load && d_rd_wr && d_rd != 0 && ((rs1_rd && rs1 == d_rd) || (rs2_rd && rs2 == d_rd));
    sb     = (rs1_rd && m_busy[rs1]) || (rs2_rd && m_busy[rs2]) || (rdu_wr && m_busy[rdu]);
    fence  = fence_u || d_fence || e_fence || m_drain;
    fstall = stall || lu || sb || fence || (i_read && !i_ready);
    chk({tag, ".ctl"}, {fs, ff, ds, df, es, ef, ms, mf},
        {fstall, 1'b0, stall, fstall || mispred, stall, stall || mispred, stall, stall});
    chk({tag, ".busy"}, busy, m_vec());
    chk({tag, ".count"}, count, m_pop());
    chk({tag, ".drain"}, drain, m_drain);
    chk({tag, ".timeout"}, tout, m_to);
    n_busy = m_busy;
    if (wb_v) n_busy[wb_rd] = 0;
    if (iss_v && !stall && !mispred && iss_rd != 0) n_busy[iss_rd] = 1;
    if (!m_drain && e_fence && !stall) m_drain = 1;
    else if (m_drain && m_pop() == 0 && !bw) m_drain = 0;
    m_busy = n_busy;
    if (!bw) begin m_cnt = 0; m_to = 0; end
    else if (m_cnt == TO-1) begin m_cnt = 0; m_to = 1; end
    else begin m_cnt++; m_to = 0; end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.count", count, 0);
    chk("rst.state", {drain, tout}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_mode = 0;
    clear();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ctl", {fs, ff, ds, df, es, ef, ms, mf}, 0);
    chk("reset.busy", busy, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // Plan 1: mul to r5, dependent read stalls until writeback.
    iss_v = 1; iss_rd = 5; step("p1.issue"); clear();
    rs1 = 5; rs1_rd = 1; step("p1.dep");
    chk("p1.stall", {fs, df, busy[5], count}, {3'b111, 6'd1});
    wb_v = 1; wb_rd = 5; step("p1.wb"); wb_v = 0;
    step("p1.free");
    chk("p1.released", {fs, count}, 0);
    clear();
    // Plan 2: load-use, then rd=0 load.
    d_load = 1; d_rd_wr = 1; d_rd = 7; rs2 = 7; rs2_rd = 1; step("p2.lu");
    chk("p2.stall", fs, 1);
    d_rd = 0; rs2 = 0; step("p2.x0");
    chk("p2.nostall", fs, 0);
    clear();
    // Plan 3: issue squashed by mispredict.
    iss_v = 1; iss_rd = 9; mispred = 1; step("p3.squash"); clear();
    step("p3.after");
    chk("p3.busy9", busy[9], 0);
    // Plan 4: set wins over same-cycle clear; r0 never busy.
    iss_v = 1; iss_rd = 3; step("p4.set");
    wb_v = 1; wb_rd = 3; step("p4.both"); iss_v = 0;
    chk("p4.still", busy[3], 1);
    step("p4.clr"); wb_v = 0;
    iss_v = 1; iss_rd = 0; step("p4.r0"); clear();
    step("p4.end");
    chk("p4.empty", count, 0);
    // Plan 5: fence drains while r4 is busy.
    iss_v = 1; iss_rd = 4; step("p5.set"); clear();
    e_fence = 1; step("p5.fence"); e_fence = 0;
    step("p5.drain");
    wb_v = 1; wb_rd = 4; step("p5.wb"); clear();
    repeat (3) step("p5.exit");
    chk("p5.idle", {drain, fs}, 0);
    // Plan 6: data-bus timeout pulses, then reset mid-wait.
    iss_v = 1; iss_rd = 12; step("p6.set"); clear();
    d_read = 1; d_ready = 0;
    repeat (10) step("p6.wait");
    e_fence = 1; step("p6.fence"); e_fence = 0;
    do_reset();
    step("p6.post");
    clear();
    // Random traffic with sticky bus-wait bursts so timeouts recur.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) wait_mode = 1 - wait_mode;
      rs1 = RB'($urandom_range(0, 7)); rs1_rd = 1'($urandom);
      rs2 = RB'($urandom_range(0, 7)); rs2_rd = 1'($urandom);
      rdu = RB'($urandom_range(0, 7)); rdu_wr = 1'($urandom);
      d_rd = RB'($urandom_range(0, 7)); d_load = 1'($urandom); d_rd_wr = 1'($urandom);
      fence_u = $urandom_range(0, 15) == 0; d_fence = $urandom_range(0, 15) == 0;
      e_fence = $urandom_range(0, 9) == 0;
      iss_v = $urandom_range(0, 2) == 0; iss_rd = RB'($urandom_range(0, 7));
      wb_v = $urandom_range(0, 2) == 0; wb_rd = RB'($urandom_range(0, 7));
      m_rd_wr = $urandom_range(0, 3) == 0; mispred = $urandom_range(0, 7) == 0;
      i_read = 1'($urandom); i_ready = $urandom_range(0, 3) != 0;
      d_read = wait_mode != 0 || $urandom_range(0, 3) == 0; d_write = 1'($urandom);
      d_ready = wait_mode == 0 && $urandom_range(0, 3) != 0;
      step("rand");
      if (i == 300) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised next-generation pipeline hazard controller for the 5-stage core (fetch/decode/execute/mem/writeback). It keeps the existing combinational load-use, bus-wait and mispredict stall/flush network, and adds three pieces of state:
- a per-register scoreboard for long-latency multi-cycle (mul/div) results;
- a fence-drain state machine;
- a data-bus timeout counter.
It drives stall/flush for all four stage registers.

Parameters:
REG_BITS, 5, register index width; NUM_REGS = 2**REG_BITS
TIMEOUT_CYCLES, 256, consecutive data-bus wait cycles before a timeout pulse (>=2)
CNT_BITS, 9, timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
clk_in  in  1  clock
reset_n_in  in  1  asynchronous active-low reset
decode_rs1_unreg_in  in  REG_BITS  rs1 of instruction entering decode
decode_rs1_read_unreg_in  in  1  rs1 used
decode_rs2_unreg_in  in  REG_BITS  rs2 of instruction entering decode
decode_rs2_read_unreg_in  in  1  rs2 used
decode_rd_unreg_in  in  REG_BITS  rd of instruction entering decode (WAW check)
decode_rd_write_unreg_in  in  1  rd written
decode_mem_fence_unreg_in  in  1  fence entering decode
decode_mem_read_in  in  1  instruction in decode is a load
decode_mem_fence_in  in  1  fence in decode
decode_rd_in  in  REG_BITS  rd in decode
decode_rd_write_in  in  1  rd written by instruction in decode
execute_mem_fence_in  in  1  fence in execute
execute_issue_valid_in  in  1  multi-cycle op issued from execute this cycle
execute_issue_rd_in  in  REG_BITS  its destination
wb_complete_valid_in  in  1  multi-cycle unit writing back this cycle
wb_complete_rd_in  in  REG_BITS  its destination
mem_rd_write_in  in  1  instruction in mem will use writeback port next cycle
mem_branch_mispredicted_in  in  1  mispredict resolved in mem
instr_read_in, instr_ready_in  in  1  instruction bus
data_read_in, data_write_in, data_ready_in  in  1  data bus
fetch_stall_out, fetch_flush_out  out  1
decode_stall_out, decode_flush_out  out  1
execute_stall_out, execute_flush_out  out  1
mem_stall_out, mem_flush_out  out  1
scoreboard_busy_out  out  NUM_REGS  busy bit per register
scoreboard_count_out  out  REG_BITS+1  number of busy registers
fence_draining_out  out  1  FSM in DRAIN
data_timeout_out  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, reset_n_in low):
  - scoreboard = 0; FSM = IDLE; timeout counter = 0; data_timeout_out = 0.
  - Stall/flush outputs are combinational and follow their equations from the reset state.
- Scoreboard set: on posedge with execute_issue_valid_in && !execute_stall_out && !mem_branch_mispredicted_in && execute_issue_rd_in != 0, set busy[rd].
  - An issue in the same cycle as a mispredict belongs to a younger, squashed instruction and is ignored.
- Scoreboard clear: on posedge with wb_complete_valid_in, clear busy[wb_complete_rd_in].
  - Clearing an idle register is a no-op.
  - Same-cycle set and clear of the same register: set wins; register stays busy.
- busy[0] is always 0. scoreboard_count_out is the registered popcount of the busy bits.
- Combinational hazard terms:
  - rs1_hit = rs1_read && busy[rs1]; rs2_hit likewise.
  - waw_hit = decode_rd_write_unreg_in && busy[decode_rd_unreg_in].
  - sb_wait = rs1_hit || rs2_hit || waw_hit.
  - load_use = (rs1/rs2_unreg == decode_rd_in, with matching read flag) && decode_rd_in != 0 && decode_mem_read_in && decode_rd_write_in.
  - fence_seen = decode_mem_fence_unreg_in || decode_mem_fence_in || execute_mem_fence_in || FSM==DRAIN.
  - fetch_bus_wait = instr_read_in && !instr_ready_in.
  - mem_bus_wait = (data_read_in || data_write_in) && !data_ready_in.
  - wb_conflict = wb_complete_valid_in && mem_rd_write_in. The multi-cycle unit owns the write port; mem stalls.
- Outputs:
  - mem_stall_out = mem_bus_wait || wb_conflict
  - mem_flush_out = execute_stall_out
  - execute_stall_out = mem_stall_out
  - execute_flush_out = decode_stall_out || mem_branch_mispredicted_in
  - decode_stall_out = execute_stall_out
  - decode_flush_out = fetch_stall_out || mem_branch_mispredicted_in
  - fetch_stall_out = decode_stall_out || load_use || sb_wait || fence_seen || fetch_bus_wait
  - fetch_flush_out = 0
- Fence FSM:
  - IDLE -> DRAIN when execute_mem_fence_in && !execute_stall_out.
  - DRAIN -> IDLE when scoreboard empty && !mem_bus_wait.
  - Both exit conditions hold on the entry cycle: the FSM still spends exactly one cycle in DRAIN.
  - A mispredict does not abort DRAIN; the fence is older than the branch.
- Timeout counter:
  - Increments each cycle mem_bus_wait is high; clears to 0 when it is low.
  - At count == TIMEOUT_CYCLES-1 with mem_bus_wait still high: data_timeout_out is registered high for the following cycle and the counter wraps to 0.
  - The stall continues; the block never drops a pending access.
- Reset mid-operation: all state clears immediately; no pending clears are replayed.

Test Plan:
1. Issue mul to rd=5. Next cycle decode rs1=5 read -> fetch_stall_out=1, decode_flush_out=1, busy[5]=1, count=1. wb_complete rd=5 -> stall drops the following cycle, count=0.
2. Load in decode with rd=7; rs2_unreg=7 read -> fetch_stall_out=1 for one cycle. Repeat with rd=0 -> no stall.
3. execute_issue_valid_in and mem_branch_mispredicted_in both high, rd=9 -> busy[9] stays 0; execute_flush_out=1, decode_flush_out=1.
4. Same-cycle issue rd=3 and complete rd=3 while busy[3]=1 -> busy[3]=1. Complete rd=3 alone -> 0. Issue rd=0 -> count unchanged.
5. busy[4]=1, fence in execute -> DRAIN, fetch_stall_out=1. Complete rd=4 while data_ready_in=1 -> IDLE next cycle, fetch_stall_out=0.
6. TIMEOUT_CYCLES=4, data_read_in=1 and data_ready_in=0 for 10 cycles -> data_timeout_out pulses after 4 and 8 wait cycles; mem_stall_out=1 throughout. Assert reset_n_in low mid-wait -> counter=0, FSM=IDLE, scoreboard=0.
